scariv_muldiv_issue_fifo: RTL
=============================

Name: scariv_muldiv_issue_fifo

Overview:
In-order issue queue that sits directly upstream of the mul/div execution pipe. It accepts dispatched mul/div micro-ops and captures operand values from register-file reads at dispatch or from writeback wakeup broadcasts. It issues the oldest micro-op once both operands are ready and the pipe is not stalled. Entries flushed by a commit or branch are discarded without issue.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2.
WAKE_PORTS, 2, number of writeback wakeup broadcast ports.
RV_ENTRY_SIZE, 32, width of the one-hot slot index forwarded to the pipe.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_commit  in  scariv_pkg::commit_blk_t  commit notification, used for commit flush.
br_upd_if  slave  br_upd_if  branch resolution: update, brtag, dead, mispredict.
i_disp_valid  in  1  dispatch request.
o_disp_ready  out  1  queue can accept a dispatch this cycle.
i_disp_op  in  op_t  mul/div operation.
i_disp_cmt_id / i_disp_grp_id / i_disp_br_mask  in  scariv_pkg types  ordering and speculation tags.
i_disp_rd_rnid / i_disp_rd_type  in  scariv_pkg types  destination register.
i_disp_index_oh  in  RV_ENTRY_SIZE  one-hot slot index, carried unchanged.
i_disp_rs_rnid[2]  in  scariv_pkg::rnid_t  source physical registers.
i_disp_rs_ready[2]  in  1  source value is valid at dispatch.
i_disp_rs_data[2]  in  riscv_pkg::xlen_t  source value; meaningful only when the matching ready bit is 1.
i_wake_valid[WAKE_PORTS]  in  1  writeback broadcast valid.
i_wake_rnid[WAKE_PORTS]  in  rnid_t  written register.
i_wake_data[WAKE_PORTS]  in  xlen_t  written value.
i_stall  in  1  stall from the mul/div pipe.
o_valid  out  1  issue valid.
o_op, o_cmt_id, o_grp_id, o_br_mask, o_rd_rnid, o_rd_type, o_index_oh, o_rs1, o_rs2  out  matching types  issued micro-op fields and operand values.
o_empty  out  1  no live or dead entries are held.

Behaviour:
- Reset: head, tail and count are 0 and all entries are invalid. o_valid=0, o_disp_ready=1, o_empty=1, all other outputs 0.
- Storage: circular buffer with head and tail pointers that wrap modulo DEPTH, plus a count from 0 to DEPTH.
- Per-entry state: valid, dead, op and tags, br_mask, rs_ready[2], rs_data[2], rs_rnid[2].
- o_disp_ready = (count < DEPTH), computed from current-cycle state only. A pop in the same cycle does not free a slot for that cycle's dispatch.
- Push: occurs when i_disp_valid & o_disp_ready.
  - The entry is written at tail and tail advances.
  - If the dispatched op is itself flushed this cycle (commit or branch flush target), the entry is written dead.
- Wakeup:
  - Each cycle, every valid entry source with rs_ready=0 whose rnid matches a valid wake port sets rs_ready=1 and captures that port's data.
  - If several ports match, the lowest-numbered port wins.
  - Wakeup also applies to a source being dispatched in the same cycle.
  - No same-cycle issue bypass: an operand woken in cycle N makes its entry eligible in cycle N+1.
- Branch resolve: on br_upd_if.update, bit brtag is cleared in every entry's br_mask and in the mask of any dispatch that cycle. If the entry is a flush target it is marked dead first.
- Commit flush: scariv_pkg::is_commit_flush_target evaluated per entry; a match marks the entry dead.
- Issue:
  - o_valid = head valid & ~dead & both rs_ready & ~i_stall & ~(head flushed this cycle).
  - Issue is combinational from head state; head pops in the same cycle o_valid=1.
  - o_br_mask already has any brtag resolved this cycle cleared.
  - Issue is strictly in order: a non-ready head blocks younger ready entries.
- Dead head: popped without issue at one per cycle, independent of i_stall. o_valid=0 in that cycle.
- Count:
  - Push only: count+1.
  - Pop only (issue or dead drain): count-1.
  - Push and pop in the same cycle (possible only when count<DEPTH): count unchanged.
- o_empty = (count==0).
- Reset asserted mid-operation discards all entries immediately; outputs return to reset values asynchronously.

Test Plan:
1. Dispatch MUL with both sources ready, rs1=7, rs2=6, i_stall=0. The op issues the next cycle (o_valid=1, o_rs1=7, o_rs2=6). Count returns to 0 and o_empty=1.
2. Dispatch DIV with rs2 not ready (rnid 12), then wake rnid 12 with data 0x3 in cycle 3. o_valid stays 0 through cycle 3 and goes to 1 in cycle 4 with o_rs2=3.
3. Fill 4 entries with i_stall=1. o_disp_ready=0 and a 5th dispatch is not accepted. Release the stall: entries issue in dispatch order over 4 cycles with matching cmt_ids, and the pointers wrap correctly for later pushes.
4. Three entries are queued: one with br_mask bit 2=0 and two with bit 2=1. Apply br_upd_if update on brtag 2 with mispredict. The two younger entries are marked dead and drained without o_valid; only the oldest issues.
5. Flush the head with a commit flush in the same cycle it would issue. o_valid=0 that cycle and the entry drains next without issue.
6. Dispatch with rs1 rnid 5 not ready while wake ports 0 and 1 both carry rnid 5 with data 0xA and 0xB. The captured operand is 0xA and the entry issues the next cycle.

Source files
------------

// File: rtl/scariv_muldiv_issue_fifo.sv
// In-order mul/div issue queue: captures operands at dispatch or wakeup; issues head combinationally (0-cycle from head state).
// Backpressure: o_disp_ready drops when full; i_stall holds a ready head, dead heads drain one per cycle regardless.
package riscv_pkg;
  localparam int XLEN_W = 64;
  typedef logic [XLEN_W-1:0] xlen_t;
endpackage

package scariv_pkg;
  localparam int RNID_W    = 6;
  localparam int CMT_ID_W  = 5;
  localparam int DISP_SIZE = 2;
  localparam int BRTAG_W   = 3;
  localparam int BRMASK_W  = 8;

  typedef logic [RNID_W-1:0]    rnid_t;
  typedef logic [CMT_ID_W-1:0]  cmt_id_t;
  typedef logic [DISP_SIZE-1:0] grp_id_t;
  typedef logic [BRTAG_W-1:0]   brtag_t;
  typedef logic [BRMASK_W-1:0]  brmask_t;

  typedef enum logic [0:0] {GPR = 1'b0, FPR = 1'b1} reg_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  typedef struct packed {
    logic    commit;
    cmt_id_t cmt_id;
    grp_id_t grp_id;
    logic    flush_valid;
  } commit_blk_t;

  // cmt_id MSB is a wrap bit: equal MSBs compare directly, differing MSBs invert the order
  function automatic logic id0_is_older_than_id1(cmt_id_t id0, cmt_id_t id1);
    if (id0[CMT_ID_W-1] == id1[CMT_ID_W-1]) return id0[CMT_ID_W-2:0] < id1[CMT_ID_W-2:0];
    else                                    return id0[CMT_ID_W-2:0] > id1[CMT_ID_W-2:0];
  endfunction

  function automatic logic is_commit_flush_target(cmt_id_t entry_cmt_id, grp_id_t entry_grp_id,
                                                  commit_blk_t commit);
    logic not_older;
    if (entry_cmt_id == commit.cmt_id) not_older = entry_grp_id >= commit.grp_id;
    else                               not_older = id0_is_older_than_id1(commit.cmt_id, entry_cmt_id);
    return commit.commit & commit.flush_valid & not_older;
  endfunction

  function automatic logic is_br_flush_target(brmask_t entry_br_mask, brtag_t brtag,
                                              logic br_dead, logic br_mispredict);
    return entry_br_mask[brtag] & (br_dead | br_mispredict);
  endfunction
endpackage

interface br_upd_if;
  logic                update;
  scariv_pkg::brtag_t  brtag;
  logic                dead;
  logic                mispredict;
  modport master (output update, brtag, dead, mispredict);
  modport slave  (input  update, brtag, dead, mispredict);
endinterface

module scariv_muldiv_issue_fifo
  import scariv_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int WAKE_PORTS    = 2,
  parameter int RV_ENTRY_SIZE = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  commit_blk_t              i_commit,
  br_upd_if.slave                  br_upd_if,
  input  logic                     i_disp_valid,
  output logic                     o_disp_ready,
  input  op_t                      i_disp_op,
  input  cmt_id_t                  i_disp_cmt_id,
  input  grp_id_t                  i_disp_grp_id,
  input  brmask_t                  i_disp_br_mask,
  input  rnid_t                    i_disp_rd_rnid,
  input  reg_t                     i_disp_rd_type,
  input  logic [RV_ENTRY_SIZE-1:0] i_disp_index_oh,
  input  rnid_t                    i_disp_rs_rnid [2],
  input  logic                     i_disp_rs_ready [2],
  input  riscv_pkg::xlen_t         i_disp_rs_data [2],
  input  logic                     i_wake_valid [WAKE_PORTS],
  input  rnid_t                    i_wake_rnid [WAKE_PORTS],
  input  riscv_pkg::xlen_t         i_wake_data [WAKE_PORTS],
  input  logic                     i_stall,
  output logic                     o_valid,
  output op_t                      o_op,
  output cmt_id_t                  o_cmt_id,
  output grp_id_t                  o_grp_id,
  output brmask_t                  o_br_mask,
  output rnid_t                    o_rd_rnid,
  output reg_t                     o_rd_type,
  output logic [RV_ENTRY_SIZE-1:0] o_index_oh,
  output riscv_pkg::xlen_t         o_rs1,
  output riscv_pkg::xlen_t         o_rs2,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                          valid;
    logic                          dead;
    op_t                           op;
    cmt_id_t                       cmt_id;
    grp_id_t                       grp_id;
    brmask_t                       br_mask;
    rnid_t                         rd_rnid;
    reg_t                          rd_type;
    logic [RV_ENTRY_SIZE-1:0]      index_oh;
    logic [1:0]                    rs_ready;
    rnid_t [1:0]                   rs_rnid;
    riscv_pkg::xlen_t [1:0]        rs_data;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] entry_flush;
  logic             disp_flush, push, pop, head_drain;
  brmask_t          br_clr;
  entry_t           disp_e;

  always_comb begin
    br_clr = '0;
    if (br_upd_if.update) br_clr[br_upd_if.brtag] = 1'b1;
    disp_flush = is_commit_flush_target(i_disp_cmt_id, i_disp_grp_id, i_commit) |
                 (br_upd_if.update & is_br_flush_target(i_disp_br_mask, br_upd_if.brtag,
                                                        br_upd_if.dead, br_upd_if.mispredict));
    for (int i = 0; i < DEPTH; i++) begin
      entry_flush[i] = entries_q[i].valid &
                       (is_commit_flush_target(entries_q[i].cmt_id, entries_q[i].grp_id, i_commit) |
                        (br_upd_if.update & is_br_flush_target(entries_q[i].br_mask, br_upd_if.brtag,
                                                               br_upd_if.dead, br_upd_if.mispredict)));
    end
  end

  always_comb begin
    o_disp_ready = count_q < CW'(DEPTH);
    push         = i_disp_valid & o_disp_ready;
    o_valid      = entries_q[head_q].valid & ~entries_q[head_q].dead & (&entries_q[head_q].rs_ready) &
                   ~i_stall & ~entry_flush[head_q];
    head_drain   = entries_q[head_q].valid & entries_q[head_q].dead;
    pop          = o_valid | head_drain;

    // Wake ports are scanned high-to-low so the lowest-numbered match is written last and wins
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        entries_d[i].dead    = entries_q[i].dead | entry_flush[i];
        entries_d[i].br_mask = entries_q[i].br_mask & ~br_clr;
        for (int s = 0; s < 2; s++) begin
          for (int p = WAKE_PORTS - 1; p >= 0; p--) begin
            if (!entries_q[i].rs_ready[s] && i_wake_valid[p] && (i_wake_rnid[p] == entries_q[i].rs_rnid[s])) begin
              entries_d[i].rs_ready[s] = 1'b1;
              entries_d[i].rs_data[s]  = i_wake_data[p];
            end
          end
        end
      end
    end

    disp_e          = '0;
    disp_e.valid    = 1'b1;
    disp_e.dead     = disp_flush;
    disp_e.op       = i_disp_op;
    disp_e.cmt_id   = i_disp_cmt_id;
    disp_e.grp_id   = i_disp_grp_id;
    disp_e.br_mask  = i_disp_br_mask & ~br_clr;
    disp_e.rd_rnid  = i_disp_rd_rnid;
    disp_e.rd_type  = i_disp_rd_type;
    disp_e.index_oh = i_disp_index_oh;
    for (int s = 0; s < 2; s++) begin
      disp_e.rs_ready[s] = i_disp_rs_ready[s];
      disp_e.rs_rnid[s]  = i_disp_rs_rnid[s];
      disp_e.rs_data[s]  = i_disp_rs_ready[s] ? i_disp_rs_data[s] : '0;
      for (int p = WAKE_PORTS - 1; p >= 0; p--) begin
        if (!i_disp_rs_ready[s] && i_wake_valid[p] && (i_wake_rnid[p] == i_disp_rs_rnid[s])) begin
          disp_e.rs_ready[s] = 1'b1;
          disp_e.rs_data[s]  = i_wake_data[p];
        end
      end
    end

    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push) begin
      entries_d[tail_q] = disp_e;
      tail_d = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    o_op       = OP_MUL;
    o_cmt_id   = '0;
    o_grp_id   = '0;
    o_br_mask  = '0;
    o_rd_rnid  = '0;
    o_rd_type  = GPR;
    o_index_oh = '0;
    o_rs1      = '0;
    o_rs2      = '0;
    if (o_valid) begin
      o_op       = entries_q[head_q].op;
      o_cmt_id   = entries_q[head_q].cmt_id;
      o_grp_id   = entries_q[head_q].grp_id;
      o_br_mask  = entries_q[head_q].br_mask & ~br_clr;
      o_rd_rnid  = entries_q[head_q].rd_rnid;
      o_rd_type  = entries_q[head_q].rd_type;
      o_index_oh = entries_q[head_q].index_oh;
      o_rs1      = entries_q[head_q].rs_data[0];
      o_rs2      = entries_q[head_q].rs_data[1];
    end
    o_empty = (count_q == '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule
